// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared router types and constants.
//   FLIT_t       : 16-bit flit. The MSB is the link valid bit, the next two bits
//                  are the flit type, and the rest is payload. The head view
//                  carries a destination field; body and tail are plain payload.
//   OUT_STATE_t  : output-unit link FSM states.
//   is_tail()    : true when a flit's type field marks the end of a packet.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int FLIT_SIZE      = 16;
    localparam int NUM_OF_FLITS   = 8;
    localparam int FLIT_VALID_BIT = FLIT_SIZE - 1;
    localparam int FLIT_TYPE_W    = 2;
    localparam int PAYLOAD_W      = FLIT_SIZE - 1 - FLIT_TYPE_W;
    localparam int DEST_W         = 4;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } FLIT_TYPE_t;

    typedef struct packed {
        logic                        valid;
        FLIT_TYPE_t                  flit_type;
        logic [DEST_W-1:0]           dest;
        logic [PAYLOAD_W-DEST_W-1:0] data;
    } HEAD_FLIT_t;

    typedef struct packed {
        logic                 valid;
        FLIT_TYPE_t           flit_type;
        logic [PAYLOAD_W-1:0] data;
    } BODY_FLIT_t;

    typedef struct packed {
        logic                 valid;
        FLIT_TYPE_t           flit_type;
        logic [PAYLOAD_W-1:0] data;
    } TAIL_FLIT_t;

    // All views share the valid bit and type field positions.
    typedef union packed {
        HEAD_FLIT_t head;
        BODY_FLIT_t body;
        TAIL_FLIT_t tail;
    } FLIT_t;

    typedef enum logic [1:0] {
        IDLE_O,
        REQ_O,
        SEND_O,
        GAP_O
    } OUT_STATE_t;

    function automatic logic is_tail(input FLIT_t f);
        return f.tail.flit_type == TAIL_FLIT;
    endfunction

endpackage

// File: rtl/sfifo.sv
// -----------------------------------------------------------------------------
// sfifo
// Synchronous first-word-fall-through FIFO of 2**ADDR_W entries.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write strobe and data (caller guarantees not full)
//   pop             : read strobe (caller guarantees not empty)
//   pop_data        : entry at the read pointer, valid whenever count != 0
//   count           : number of occupied entries, 0 .. 2**ADDR_W
// -----------------------------------------------------------------------------
module sfifo #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; the pointers and count alone define which
    // entries are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end

    assign pop_data = mem[rd_ptr];

    a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && count == '0));

endmodule

// File: rtl/output_unit.sv
// -----------------------------------------------------------------------------
// output_unit
// Transmit end of one router output link. Flits from the switch are stored in
// a FIFO; once a complete packet (tail written) is held, the unit raises
// o_downstream_req, waits for i_downstream_ack, streams the packet one flit per
// cycle with the valid bit forced high, then idles one GAP cycle before the
// next request.
//   clk, reset_n      : clock, asynchronous active-low reset
//   i_sw_valid        : switch presents i_sw_flit
//   i_sw_flit         : flit from the switch
//   o_sw_ready        : buffer can accept a flit (registered !full)
//   o_downstream_req  : transmit request to the downstream input unit
//   i_downstream_ack  : downstream grant, only sampled in REQ
//   o_flit            : flit to downstream, '0 outside SEND
//   o_port_busy       : packet buffered or transfer in progress
//   o_pkt_count       : complete packets held in the buffer
//   o_err             : sticky ack-timeout flag
// Optional feature, macro OUTPUT_UNIT_ACK_TIMEOUT_EN: REQ gives up after
// ACK_TIMEOUT cycles without ack, sets o_err and retries via GAP/IDLE.
// Without the macro REQ waits indefinitely and o_err is tied low.
// -----------------------------------------------------------------------------
module output_unit
    import router_pkg::*;
#(
    parameter int FLIT_SIZE   = router_pkg::FLIT_SIZE,
    parameter int DEPTH       = router_pkg::NUM_OF_FLITS,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_sw_valid,
    input  FLIT_t                  i_sw_flit,
    output logic                   o_sw_ready,
    output logic                   o_downstream_req,
    input  logic                   i_downstream_ack,
    output FLIT_t                  o_flit,
    output logic                   o_port_busy,
    output logic [$clog2(DEPTH):0] o_pkt_count,
    output logic                   o_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    if (FLIT_SIZE != $bits(FLIT_t) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0
        || ACK_TIMEOUT < 1) begin : g_param_check
        $error("output_unit: illegal parameter combination");
    end

    OUT_STATE_t       state;
    OUT_STATE_t       state_next;
    logic             req_next;
    FLIT_t            flit_next;
    logic             wr_en;
    logic             rd_en;
    FLIT_t            fifo_rd;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_next;
    logic [CNT_W-1:0] pkt_next;
    logic             pkt_inc;
    logic             pkt_dec;
    logic             ready_next;
    logic             busy_next;

`ifdef OUTPUT_UNIT_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] timer_q;
    logic [TO_W-1:0] timer_next;
    logic            err_next;
`endif

    sfifo #(
        .WIDTH  (FLIT_SIZE),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wr_en),
        .push_data (i_sw_flit),
        .pop       (rd_en),
        .pop_data  (fifo_rd),
        .count     (fifo_count)
    );

    assign wr_en = i_sw_valid && o_sw_ready;

    // A tail in and a tail out on the same edge cancel in the sum.
    assign pkt_inc  = wr_en && is_tail(i_sw_flit);
    assign pkt_dec  = rd_en && is_tail(fifo_rd);
    assign pkt_next = o_pkt_count + CNT_W'(pkt_inc) - CNT_W'(pkt_dec);

    // Registered status is computed from next-cycle occupancy so the flops
    // show exactly what combinational !full / !empty would.
    assign fifo_count_next = fifo_count + CNT_W'(wr_en) - CNT_W'(rd_en);
    assign ready_next      = (fifo_count_next != CNT_W'(DEPTH));
    assign busy_next       = (state_next != IDLE_O) || (fifo_count_next != '0);

    always_comb begin
        // NOTE: every output of this block is defaulted before the case so no
        // path leaves one unassigned and no latch is inferred.
        state_next = state;
        req_next   = 1'b0;
        flit_next  = '0;
        rd_en      = 1'b0;
`ifdef OUTPUT_UNIT_ACK_TIMEOUT_EN
        timer_next = '0;
        err_next   = o_err;
`endif
        case (state)
            IDLE_O: begin
                // Only complete packets are counted, so a buffered head
                // without its tail never requests the link.
                if (o_pkt_count != '0) begin
                    state_next = REQ_O;
                    req_next   = 1'b1;
                end
            end
            REQ_O: begin
                if (i_downstream_ack) begin
                    // Head is popped on the ack edge so it is on the wire in
                    // the very next cycle.
                    state_next                 = SEND_O;
                    rd_en                      = 1'b1;
                    flit_next                  = fifo_rd;
                    flit_next[FLIT_VALID_BIT]  = 1'b1;
                end
`ifdef OUTPUT_UNIT_ACK_TIMEOUT_EN
                else if (timer_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    state_next = GAP_O;
                    err_next   = 1'b1;
                end else begin
                    req_next   = 1'b1;
                    timer_next = timer_q + 1'b1;
                end
`else
                else begin
                    req_next = 1'b1;
                end
`endif
            end
            SEND_O: begin
                // The flit on the wire tells us whether the packet is done;
                // the buffer always holds the rest, so there are no bubbles.
                if (is_tail(o_flit)) begin
                    state_next = GAP_O;
                end else begin
                    rd_en                     = 1'b1;
                    flit_next                 = fifo_rd;
                    flit_next[FLIT_VALID_BIT] = 1'b1;
                end
            end
            GAP_O: begin
                state_next = IDLE_O;
            end
            default: begin
                state_next = IDLE_O;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE_O;
            o_downstream_req <= 1'b0;
            o_flit           <= '0;
            o_port_busy      <= 1'b0;
            o_pkt_count      <= '0;
            o_sw_ready       <= 1'b1;
        end else begin
            state            <= state_next;
            o_downstream_req <= req_next;
            o_flit           <= flit_next;
            o_port_busy      <= busy_next;
            o_pkt_count      <= pkt_next;
            o_sw_ready       <= ready_next;
        end
    end

`ifdef OUTPUT_UNIT_ACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
            o_err   <= 1'b0;
        end else begin
            timer_q <= timer_next;
            o_err   <= err_next;
        end
    end
`else
    assign o_err = 1'b0;
`endif

    a_no_write_when_full : assert property (@(posedge clk) disable iff (!reset_n)
        !(wr_en && fifo_count == CNT_W'(DEPTH)));

endmodule
